sdrc_narrow_pack: RTL and testbench
===================================

SDRC_NARROW_PACK -- requirements
Module: sdrc_narrow_pack

Interface
REQ-001 SHALL have parameter APP_AW, default 30: application 16-bit-word address width.
REQ-002 SHALL have parameter APP_RW, default 9: request length width, for both the app and ctl sides.
REQ-003 SHALL have parameter MAX_LEN, default 16: maximum app burst in 16-bit words; buffer depth BUF_DEPTH = MAX_LEN/2+1 entries of 32 bits.
REQ-004 SHALL have clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have reset_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have app_req_addr, input, APP_AW: 16-bit-word start address.
REQ-007 SHALL have app_req_len, input, APP_RW: burst length in 16-bit words.
REQ-008 SHALL have app_req_wr_n, input, 1: 0 = write, 1 = read.
REQ-009 SHALL have app_sdr_req, input, 1: request, held until app_req_ack.
REQ-010 SHALL have app_req_ack, output, 1: request accepted (one-cycle pulse).
REQ-011 SHALL have app_req_err, output, 1: illegal length; coincides with ack.
REQ-012 SHALL have app_wr_data, input, 16: current write word.
REQ-013 SHALL have app_wr_en_n, input, 2: byte enables for app_wr_data, active-low.
REQ-014 SHALL have app_wr_next, output, 1: current write word consumed; app advances next cycle.
REQ-015 SHALL have app_rd_data / app_rd_valid, output, 16 / 1: read word and its qualifier.
REQ-016 SHALL have ctl_req_addr, output, APP_AW-1: 32-bit-word address = app_req_addr[APP_AW-1:1].
REQ-017 SHALL have ctl_req_len, output, APP_RW: 32-bit-word length.
REQ-018 SHALL have ctl_req_wr_n / ctl_sdr_req, output, 1 / 1: controller request direction and request.
REQ-019 SHALL have ctl_req_ack, input, 1: controller accepted the request.
REQ-020 SHALL have ctl_wr_data / ctl_wr_en_n, output, 32 / 4: write word and byte enables for the controller.
REQ-021 SHALL have ctl_wr_next, input, 1: controller consumed ctl_wr_data; may assert every cycle.
REQ-022 SHALL have ctl_rd_data / ctl_rd_valid, input, 32 / 1: controller read word and qualifier; may assert every cycle.

Function
REQ-023 SHALL implement states IDLE, WFILL, WREQ, WDATA, RREQ, RDATA; one request in flight.
REQ-024 In IDLE with app_sdr_req=1, SHALL assert app_req_ack combinationally that cycle and latch the request fields; the state changes on the next edge.
REQ-025 If app_req_len==0 or >MAX_LEN, SHALL assert app_req_err with ack and remain in IDLE, with no ctl activity.
REQ-026 SHALL compute ctl_req_len = (app_req_addr[0] + app_req_len + 1) >> 1.
REQ-027 Write path, WFILL: SHALL assert app_wr_next every cycle for exactly app_req_len cycles and capture app_wr_data/app_wr_en_n into successive half-slots.
REQ-028 The first half-slot SHALL be the upper half when app_req_addr[0]=1.
REQ-029 Unfilled pad halves (leading lower half, trailing upper half) SHALL carry data 0 and en_n 2'b11.
REQ-030 After the last fill, SHALL go to WREQ and hold ctl_sdr_req=1, ctl_req_wr_n=0 until ctl_req_ack, then go to WDATA.
REQ-031 In WDATA, ctl_wr_data/ctl_wr_en_n SHALL present buffer[rptr] combinationally; each ctl_wr_next advances rptr.
REQ-032 After the ctl_req_len-th ctl_wr_next, SHALL return to IDLE.
REQ-033 Read path: after ack, SHALL go to RREQ and hold ctl_sdr_req=1, ctl_req_wr_n=1 until ctl_req_ack, then go to RDATA.
REQ-034 In RDATA, SHALL write each ctl_rd_valid word into the buffer.
REQ-035 In RDATA, SHALL drain one valid half per cycle to registered app_rd_data/app_rd_valid, lower half first; the leading/trailing pad halves are discarded.
REQ-036 The first app_rd_valid SHALL occur one cycle after the ctl_rd_valid carrying the first real half.
REQ-037 A ctl_rd_valid and a drain in the same cycle SHALL both take effect.
REQ-038 After exactly app_req_len app_rd_valid pulses, SHALL return to IDLE.
REQ-039 Buffer pointers and counters SHALL wrap modulo BUF_DEPTH; the buffer cannot overflow, because ctl_req_len <= BUF_DEPTH.
REQ-040 ctl_req_addr and ctl_req_len SHALL be stable while ctl_sdr_req=1.
REQ-041 app_sdr_req arriving outside IDLE SHALL be ignored: no ack until IDLE.

Reset
REQ-042 With reset_n=0 at a clock edge, SHALL enter IDLE, clear pointers and counters, discard buffered data, and drive every output to 0 except ctl_wr_en_n=4'hF and ctl_req_wr_n=1; this applies mid-burst too.
REQ-043 After reset deasserts, SHALL accept a new request in the first IDLE cycle.

Verification
REQ-044 Write addr=0x10, len=4, data 0xA1..0xA4: 4 app_wr_next pulses, ctl_req_addr=0x8, ctl_req_len=2; ctl_wr_data 0x00A200A1 then 0x00A400A3; en_n=0.
REQ-045 Write addr=0x11, len=2, data 0xB1,0xB2: ctl_req_len=2; words 0x00B10000 (en_n 4'b0011) and 0x000000B2 (en_n 4'b1100).
REQ-046 Read addr=0x21, len=3; controller returns 0x11110000, 0x33332222 back-to-back: app_rd_data 0x1111, 0x2222, 0x3333 on consecutive cycles, 3 valids, then IDLE.
REQ-047 Request with len=0 and then len=17: ack+err each, ctl_sdr_req never asserted.
REQ-048 Read len=16 at addr=0x1 with ctl_rd_valid every cycle: ctl_req_len=9, 16 app_rd_valid pulses, no data loss.
REQ-049 reset_n=0 during WDATA: next cycle IDLE, ctl_sdr_req=0; a following read completes correctly.

Source files
------------

// File: rtl/sdrc_narrow_pack.sv
// sdrc_narrow_pack: bridges a 16-bit application port onto a 32-bit SDRAM
// controller port. Write bursts are packed into a 32-bit buffer before the
// controller request is raised; read bursts are unpacked from the buffer as
// controller words arrive, one 16-bit word per cycle.
//
// Ports
//   clk, reset_n            : clock, synchronous active-low reset
//   app_req_* / app_sdr_req : 16-bit-word request (addr, len, direction)
//   app_req_ack/err         : combinational accept pulse, illegal-length flag
//   app_wr_data/en_n/next   : write word stream, consumed while app_wr_next=1
//   app_rd_data/valid       : registered read word stream
//   ctl_req_* / ctl_sdr_req : 32-bit-word request to the controller
//   ctl_wr_data/en_n/next   : write word presented from the buffer
//   ctl_rd_data/valid       : controller read word stream
module sdrc_narrow_pack #(
  parameter int unsigned APP_AW  = 30,
  parameter int unsigned APP_RW  = 9,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [APP_AW-1:0] app_req_addr,
  input  logic [APP_RW-1:0] app_req_len,
  input  logic              app_req_wr_n,
  input  logic              app_sdr_req,
  output logic              app_req_ack,
  output logic              app_req_err,
  input  logic [15:0]       app_wr_data,
  input  logic [1:0]        app_wr_en_n,
  output logic              app_wr_next,
  output logic [15:0]       app_rd_data,
  output logic              app_rd_valid,
  output logic [APP_AW-2:0] ctl_req_addr,
  output logic [APP_RW-1:0] ctl_req_len,
  output logic              ctl_req_wr_n,
  output logic              ctl_sdr_req,
  input  logic              ctl_req_ack,
  output logic [31:0]       ctl_wr_data,
  output logic [3:0]        ctl_wr_en_n,
  input  logic              ctl_wr_next,
  input  logic [31:0]       ctl_rd_data,
  input  logic              ctl_rd_valid
);

  localparam int unsigned BUF_DEPTH = MAX_LEN / 2 + 1;
  localparam int unsigned PW        = $clog2(BUF_DEPTH);
  localparam int unsigned HW        = PW + 1;              // half-slot index
  localparam int unsigned CW        = $clog2(BUF_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WFILL = 3'd1,
    WREQ  = 3'd2,
    WDATA = 3'd3,
    RREQ  = 3'd4,
    RDATA = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [31:0]       mem_data_q [BUF_DEPTH];
  logic [3:0]        mem_en_q   [BUF_DEPTH];
  logic [APP_AW-2:0] ctl_req_addr_q;
  logic [APP_RW-1:0] ctl_req_len_q;
  logic [HW-1:0]     hidx_q;       // current half slot (fill or drain)
  logic [HW-1:0]     end_hidx_q;   // one past the last real half slot
  logic [PW-1:0]     ptr_q;        // 32-bit buffer pointer, controller side
  logic [CW-1:0]     cnt_q;        // controller words transferred
  logic [15:0]       app_rd_data_q;
  logic              app_rd_valid_q;

  logic              accept;
  logic              req_bad;
  logic [APP_RW-1:0] ctl_len_c;
  logic              fill;
  logic              wr_adv;
  logic              rd_push;
  logic              drain;
  logic [31:0]       drain_src;
  logic [15:0]       drain_data;
  logic [PW-1:0]     half_slot;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state, handshake outputs and datapath strobes
  always_comb begin
    state_d      = state_q;
    app_req_ack  = 1'b0;
    app_req_err  = 1'b0;
    app_wr_next  = 1'b0;
    ctl_sdr_req  = 1'b0;
    ctl_req_wr_n = 1'b1;
    ctl_wr_data  = 32'h0;
    ctl_wr_en_n  = 4'hF;
    accept       = 1'b0;
    fill         = 1'b0;
    wr_adv       = 1'b0;
    rd_push      = 1'b0;
    drain        = 1'b0;
    drain_src    = 32'h0;
    drain_data   = 16'h0;
    half_slot    = hidx_q[HW-1:1];
    req_bad      = (app_req_len == '0) || (app_req_len > APP_RW'(MAX_LEN));
    // An odd start address adds a leading pad half; round up to whole words.
    ctl_len_c    = APP_RW'(({1'b0, app_req_len} + (APP_RW+1)'(app_req_addr[0])
                            + (APP_RW+1)'(1)) >> 1);

    unique case (state_q)
      IDLE: begin
        if (app_sdr_req && reset_n) begin
          app_req_ack = 1'b1;
          app_req_err = req_bad;
          if (!req_bad) begin
            accept  = 1'b1;
            state_d = app_req_wr_n ? RREQ : WFILL;
          end
        end
      end
      WFILL: begin
        app_wr_next  = 1'b1;
        ctl_req_wr_n = 1'b0;
        fill         = 1'b1;
        if (hidx_q + HW'(1) == end_hidx_q) state_d = WREQ;
      end
      WREQ: begin
        ctl_sdr_req  = 1'b1;
        ctl_req_wr_n = 1'b0;
        if (ctl_req_ack) state_d = WDATA;
      end
      WDATA: begin
        ctl_req_wr_n = 1'b0;
        ctl_wr_data  = mem_data_q[ptr_q];
        ctl_wr_en_n  = mem_en_q[ptr_q];
        if (ctl_wr_next) begin
          wr_adv = 1'b1;
          if (APP_RW'(cnt_q) + APP_RW'(1) == ctl_req_len_q) state_d = IDLE;
        end
      end
      RREQ: begin
        ctl_sdr_req = 1'b1;
        if (ctl_req_ack) state_d = RDATA;
      end
      RDATA: begin
        rd_push = ctl_rd_valid && (APP_RW'(cnt_q) < ctl_req_len_q);
        // Drain from the buffer when the slot is already stored, or straight
        // from the incoming controller word when it is the one arriving now.
        if (HW'(half_slot) < HW'(cnt_q)) begin
          drain     = 1'b1;
          drain_src = mem_data_q[half_slot];
        end else if (rd_push && (HW'(half_slot) == HW'(cnt_q))) begin
          drain     = 1'b1;
          drain_src = ctl_rd_data;
        end
        drain_data = hidx_q[0] ? drain_src[31:16] : drain_src[15:0];
        if (drain && (hidx_q + HW'(1) == end_hidx_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, buffer, pointers and read output register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctl_req_addr_q <= '0;
      ctl_req_len_q  <= '0;
      hidx_q         <= '0;
      end_hidx_q     <= '0;
      ptr_q          <= '0;
      cnt_q          <= '0;
      app_rd_data_q  <= 16'h0;
      app_rd_valid_q <= 1'b0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_data_q[i] <= 32'h0;
        mem_en_q[i]   <= 4'hF;
      end
    end else begin
      app_rd_valid_q <= drain;
      if (drain) begin
        app_rd_data_q <= drain_data;
        hidx_q        <= hidx_q + HW'(1);
      end
      if (accept) begin
        ctl_req_addr_q <= app_req_addr[APP_AW-1:1];
        ctl_req_len_q  <= ctl_len_c;
        hidx_q         <= HW'(app_req_addr[0]);
        end_hidx_q     <= HW'(app_req_addr[0]) + HW'(app_req_len);
        ptr_q          <= '0;
        cnt_q          <= '0;
        // Pre-pad every slot so untouched halves go out as masked zeros.
        for (int i = 0; i < int'(BUF_DEPTH); i++) begin
          mem_data_q[i] <= 32'h0;
          mem_en_q[i]   <= 4'hF;
        end
      end
      if (fill) begin
        hidx_q <= hidx_q + HW'(1);
        if (hidx_q[0]) begin
          mem_data_q[half_slot][31:16] <= app_wr_data;
          mem_en_q[half_slot][3:2]     <= app_wr_en_n;
        end else begin
          mem_data_q[half_slot][15:0]  <= app_wr_data;
          mem_en_q[half_slot][1:0]     <= app_wr_en_n;
        end
      end
      if (wr_adv) begin
        ptr_q <= ptr_inc(ptr_q);
        cnt_q <= cnt_q + CW'(1);
      end
      if (rd_push) begin
        mem_data_q[ptr_q] <= ctl_rd_data;
        ptr_q             <= ptr_inc(ptr_q);
        cnt_q             <= cnt_q + CW'(1);
      end
    end
  end

  assign ctl_req_addr = ctl_req_addr_q;
  assign ctl_req_len  = ctl_req_len_q;
  assign app_rd_data  = app_rd_data_q;
  assign app_rd_valid = app_rd_valid_q;

endmodule

// File: tb/tb_sdrc_narrow_pack.sv
// Testbench for sdrc_narrow_pack: directed write/read bursts with expected
// controller requests, controller write words and application read words
// queued by the stimulus and consumed by a negedge monitor.
module tb_sdrc_narrow_pack;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] app_req_addr;
  logic [8:0]  app_req_len;
  logic        app_req_wr_n;
  logic        app_sdr_req;
  logic        app_req_ack;
  logic        app_req_err;
  logic [15:0] app_wr_data;
  logic [1:0]  app_wr_en_n;
  logic        app_wr_next;
  logic [15:0] app_rd_data;
  logic        app_rd_valid;
  logic [28:0] ctl_req_addr;
  logic [8:0]  ctl_req_len;
  logic        ctl_req_wr_n;
  logic        ctl_sdr_req;
  logic        ctl_req_ack;
  logic [31:0] ctl_wr_data;
  logic [3:0]  ctl_wr_en_n;
  logic        ctl_wr_next;
  logic [31:0] ctl_rd_data;
  logic        ctl_rd_valid;

  sdrc_narrow_pack dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .app_req_addr (app_req_addr),
    .app_req_len  (app_req_len),
    .app_req_wr_n (app_req_wr_n),
    .app_sdr_req  (app_sdr_req),
    .app_req_ack  (app_req_ack),
    .app_req_err  (app_req_err),
    .app_wr_data  (app_wr_data),
    .app_wr_en_n  (app_wr_en_n),
    .app_wr_next  (app_wr_next),
    .app_rd_data  (app_rd_data),
    .app_rd_valid (app_rd_valid),
    .ctl_req_addr (ctl_req_addr),
    .ctl_req_len  (ctl_req_len),
    .ctl_req_wr_n (ctl_req_wr_n),
    .ctl_sdr_req  (ctl_sdr_req),
    .ctl_req_ack  (ctl_req_ack),
    .ctl_wr_data  (ctl_wr_data),
    .ctl_wr_en_n  (ctl_wr_en_n),
    .ctl_wr_next  (ctl_wr_next),
    .ctl_rd_data  (ctl_rd_data),
    .ctl_rd_valid (ctl_rd_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rd_seen  = 0;
  int ctl0_cyc = -1;
  logic mon_en = 1'b0;
  logic saw_ctl_req = 1'b0;

  logic        exp_ack_q [$];
  logic [63:0] exp_req_q [$];
  logic [63:0] exp_wr_q  [$];
  logic [15:0] exp_rd_q  [$];
  int          rd_cyc_q  [$];

  logic [15:0] wwords [16];
  logic [1:0]  wen    [16];
  logic [31:0] rwords [16];
  logic        rgap   [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] req_word(input logic [28:0] a, input logic [8:0] l, input logic w);
    return 64'({a, l, w});
  endfunction

  // Monitor: compares every DUT presentation against the scoreboard queues
  always @(negedge clk) begin
    if (mon_en) begin
      if (app_req_ack) begin
        if (exp_ack_q.size() == 0) check("unexpected_ack", 64'(app_req_ack), 64'd0);
        else check("ack_err", 64'(app_req_err), 64'(exp_ack_q.pop_front()));
      end
      if (ctl_sdr_req) begin
        saw_ctl_req = 1'b1;
        if (exp_req_q.size() == 0) check("unexpected_ctl_req", 64'(ctl_sdr_req), 64'd0);
        else begin
          check("ctl_req_fields", req_word(ctl_req_addr, ctl_req_len, ctl_req_wr_n), exp_req_q[0]);
          if (ctl_req_ack) void'(exp_req_q.pop_front());
        end
      end
      if (ctl_wr_next) begin
        if (exp_wr_q.size() == 0) check("ctl_wr_exp_avail", 64'(exp_wr_q.size()), 64'd1);
        else check("ctl_wr_word", 64'({ctl_wr_data, ctl_wr_en_n}), exp_wr_q.pop_front());
      end
      if (ctl_rd_valid && ctl0_cyc < 0) ctl0_cyc = cyc;
      if (app_rd_valid) begin
        rd_seen++;
        rd_cyc_q.push_back(cyc);
        if (exp_rd_q.size() == 0) check("unexpected_rd_valid", 64'(app_rd_valid), 64'd0);
        else check("app_rd_data", 64'(app_rd_data), 64'(exp_rd_q.pop_front()));
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic do_req(input logic [29:0] addr, input logic [8:0] len, input logic wr_n,
                        input logic exp_err);
    int lat;
    lat = -1;
    exp_ack_q.push_back(exp_err);
    app_req_addr = addr; app_req_len = len; app_req_wr_n = wr_n; app_sdr_req = 1'b1;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (app_req_ack) lat = c;
      @(posedge clk); #1;
    end
    app_sdr_req = 1'b0;
    check("ack_latency", 64'(lat), 64'd0);
  endtask

  task automatic feed_write(input int len);
    int n;
    n = 0;
    app_wr_data = wwords[0]; app_wr_en_n = wen[0];
    for (int c = 0; c < 40 && n < len; c++) begin
      @(negedge clk);
      if (app_wr_next) n++;
      @(posedge clk); #1;
      if (n < len) begin app_wr_data = wwords[n]; app_wr_en_n = wen[n]; end
    end
    check("wr_next_count", 64'(n), 64'(len));
    @(negedge clk);
    check("wr_next_stops", 64'(app_wr_next), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic ctl_ack(input int delay);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (ctl_sdr_req) got = 1'b1;
      @(posedge clk); #1;
    end
    check("ctl_req_seen", 64'(got), 64'd1);
    repeat (delay) begin @(posedge clk); #1; end
    ctl_req_ack = 1'b1;
    @(posedge clk); #1;
    ctl_req_ack = 1'b0;
  endtask

  task automatic ctl_write(input int n);
    for (int i = 0; i < n; i++) begin
      ctl_wr_next = 1'b1;
      @(posedge clk); #1;
    end
    ctl_wr_next = 1'b0;
  endtask

  task automatic ctl_read(input int n);
    for (int j = 0; j < n; j++) begin
      if (rgap[j]) begin ctl_rd_valid = 1'b0; @(posedge clk); #1; end
      ctl_rd_data = rwords[j]; ctl_rd_valid = 1'b1;
      @(posedge clk); #1;
    end
    ctl_rd_valid = 1'b0;
  endtask

  task automatic wait_rd(input int n);
    for (int c = 0; c < 60 && rd_seen < n; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("rd_valid_count", 64'(rd_seen), 64'(n));
  endtask

  task automatic post_check(input string name);
    @(negedge clk);
    check({name, "_idle_no_req"}, 64'(ctl_sdr_req), 64'd0);
    check({name, "_queues_empty"},
          64'(exp_req_q.size() + exp_wr_q.size() + exp_rd_q.size() + exp_ack_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic start_read;
    rd_seen = 0; ctl0_cyc = -1; rd_cyc_q.delete();
    for (int j = 0; j < 16; j++) rgap[j] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; app_req_addr = '0; app_req_len = '0; app_req_wr_n = 1'b0;
    app_sdr_req = 1'b0; app_wr_data = '0; app_wr_en_n = 2'b00; ctl_req_ack = 1'b0;
    ctl_wr_next = 1'b0; ctl_rd_data = '0; ctl_rd_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin wwords[j] = '0; wen[j] = 2'b00; rwords[j] = '0; rgap[j] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_app_outs", 64'({app_req_ack, app_req_err, app_wr_next, app_rd_valid, app_rd_data}), 64'd0);
    check("rst_ctl_req", 64'({ctl_sdr_req, ctl_req_wr_n, ctl_req_addr, ctl_req_len}),
          64'({1'b0, 1'b1, 29'd0, 9'd0}));
    check("rst_ctl_wr", 64'({ctl_wr_data, ctl_wr_en_n}), 64'({32'h0, 4'hF}));
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Aligned write, four words
    wwords[0] = 16'h00A1; wwords[1] = 16'h00A2; wwords[2] = 16'h00A3; wwords[3] = 16'h00A4;
    exp_req_q.push_back(req_word(29'h8, 9'd2, 1'b0));
    exp_wr_q.push_back(64'({32'h00A2_00A1, 4'h0}));
    exp_wr_q.push_back(64'({32'h00A4_00A3, 4'h0}));
    do_req(30'h10, 9'd4, 1'b0, 1'b0);
    feed_write(4);
    ctl_ack(2);
    ctl_write(2);
    post_check("w_aligned");

    // Odd-address write, leading and trailing pads
    wwords[0] = 16'h00B1; wwords[1] = 16'h00B2;
    exp_req_q.push_back(req_word(29'h8, 9'd2, 1'b0));
    exp_wr_q.push_back(64'({32'h00B1_0000, 4'b0011}));
    exp_wr_q.push_back(64'({32'h0000_00B2, 4'b1100}));
    do_req(30'h11, 9'd2, 1'b0, 1'b0);
    feed_write(2);
    ctl_ack(0);
    ctl_write(2);
    post_check("w_odd");

    // Odd-address read, back-to-back controller data; new request ignored while busy
    start_read();
    rwords[0] = 32'h1111_0000; rwords[1] = 32'h3333_2222;
    exp_req_q.push_back(req_word(29'h10, 9'd2, 1'b1));
    exp_rd_q.push_back(16'h1111); exp_rd_q.push_back(16'h2222); exp_rd_q.push_back(16'h3333);
    do_req(30'h21, 9'd3, 1'b1, 1'b0);
    app_req_addr = 30'h0; app_req_len = 9'd5; app_req_wr_n = 1'b0; app_sdr_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_no_ack", 64'(app_req_ack), 64'd0);
      @(posedge clk); #1;
    end
    app_sdr_req = 1'b0;
    ctl_ack(0);
    ctl_read(2);
    wait_rd(3);
    if (rd_cyc_q.size() == 3) begin
      check("rd_first_latency", 64'(rd_cyc_q[0] - ctl0_cyc), 64'd1);
      check("rd_back_to_back", 64'(rd_cyc_q[2] - rd_cyc_q[0]), 64'd2);
    end else check("rd_cyc_count", 64'(rd_cyc_q.size()), 64'd3);
    post_check("r_odd");

    // Aligned read with a gap between controller words
    start_read();
    rwords[0] = 32'h2222_1111; rwords[1] = 32'h4444_3333; rgap[1] = 1'b1;
    exp_req_q.push_back(req_word(29'h18, 9'd2, 1'b1));
    exp_rd_q.push_back(16'h1111); exp_rd_q.push_back(16'h2222);
    exp_rd_q.push_back(16'h3333); exp_rd_q.push_back(16'h4444);
    do_req(30'h30, 9'd4, 1'b1, 1'b0);
    ctl_ack(1);
    ctl_read(2);
    wait_rd(4);
    post_check("r_gap");

    // Illegal lengths: error with ack, no controller request
    saw_ctl_req = 1'b0;
    do_req(30'h40, 9'd0, 1'b1, 1'b1);
    do_req(30'h40, 9'd17, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("err_no_ctl_req", 64'(saw_ctl_req), 64'd0);
    post_check("err_len");

    // Maximum-length odd read, controller data every cycle
    start_read();
    for (int j = 0; j < 9; j++) rwords[j] = {16'h5000 + 16'(2*j + 1), 16'h5000 + 16'(2*j)};
    for (int k = 1; k <= 16; k++) exp_rd_q.push_back(16'h5000 + 16'(k));
    exp_req_q.push_back(req_word(29'h0, 9'd9, 1'b1));
    do_req(30'h1, 9'd16, 1'b1, 1'b0);
    ctl_ack(1);
    ctl_read(9);
    wait_rd(16);
    post_check("r_max");

    // Reset in the middle of controller write data, then a read
    wwords[0] = 16'h00C1; wwords[1] = 16'h00C2; wwords[2] = 16'h00C3; wwords[3] = 16'h00C4;
    exp_req_q.push_back(req_word(29'h8, 9'd2, 1'b0));
    exp_wr_q.push_back(64'({32'h00C2_00C1, 4'h0}));
    do_req(30'h10, 9'd4, 1'b0, 1'b0);
    feed_write(4);
    ctl_ack(0);
    ctl_write(1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_ctl_req", 64'({ctl_sdr_req, ctl_req_wr_n, ctl_req_addr, ctl_req_len}),
          64'({1'b0, 1'b1, 29'd0, 9'd0}));
    check("midrst_ctl_wr", 64'({ctl_wr_data, ctl_wr_en_n}), 64'({32'h0, 4'hF}));
    check("midrst_app_outs", 64'({app_wr_next, app_rd_valid, app_rd_data}), 64'd0);
    @(posedge clk); #1;
    start_read();
    rwords[0] = 32'hBEEF_CAFE;
    exp_req_q.push_back(req_word(29'h2, 9'd1, 1'b1));
    exp_rd_q.push_back(16'hCAFE); exp_rd_q.push_back(16'hBEEF);
    do_req(30'h4, 9'd2, 1'b1, 1'b0);
    ctl_ack(0);
    ctl_read(1);
    wait_rd(2);
    post_check("r_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
